// File: rtl/pciecfg_pkg.sv
// rtl/pciecfg_pkg.sv - shared request/response word type, constants and arbiter state enum
package pciecfg_pkg;

    typedef struct packed {
        logic [7:0]  tag;
        logic        wr;
        logic [3:0]  be;
        logic [11:0] addr;
        logic [31:0] data;
    } FIFO_PCIECFG_T;

    localparam logic [31:0] PCIECFG_TIMEOUT_DATA = 32'hFFFF_FFFF;
    localparam logic [3:0]  PCIECFG_STALE_MAX    = 4'd15;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_DELIVER
    } PCIECFG_ARB_STATE_T;

endpackage

// File: rtl/pciecfg_arb_if.sv
// rtl/pciecfg_arb_if.sv - requester, core and status signals of the pciecfg arbiter
interface pciecfg_arb_if #(
    parameter int N_REQ = 2
);
    import pciecfg_pkg::*;

    logic [N_REQ-1:0] req_rd_en;
    logic [N_REQ-1:0] req_empty;
    FIFO_PCIECFG_T    req_dout [N_REQ];
    logic [N_REQ-1:0] rsp_wr_en;
    logic [N_REQ-1:0] rsp_full;
    FIFO_PCIECFG_T    rsp_din;
    logic             core_req_wr_en;
    logic             core_req_full;
    FIFO_PCIECFG_T    core_req_din;
    logic             core_rsp_rd_en;
    logic             core_rsp_empty;
    FIFO_PCIECFG_T    core_rsp_dout;
    logic             busy;
    logic [15:0]      stat_timeout_cnt;

    modport master (
        output req_rd_en, rsp_wr_en, rsp_din, core_req_wr_en, core_req_din,
               core_rsp_rd_en, busy, stat_timeout_cnt,
        input  req_empty, req_dout, rsp_full, core_req_full, core_rsp_empty, core_rsp_dout
    );

    modport slave (
        input  req_rd_en, rsp_wr_en, rsp_din, core_req_wr_en, core_req_din,
               core_rsp_rd_en, busy, stat_timeout_cnt,
        output req_empty, req_dout, rsp_full, core_req_full, core_rsp_empty, core_rsp_dout
    );

endinterface

// File: rtl/pciecfg_arb_rr_pick.sv
// rtl/pciecfg_arb_rr_pick.sv - combinational round-robin picker: first requester after last, cyclically
module rr_pick #(
    parameter int N = 2,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [W-1:0] grant,
    output logic         valid
);

    logic [W-1:0] idx;

    // Scan from the farthest candidate inward so the nearest hit after last wins.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int i = N; i >= 1; i--) begin
            idx = W'((int'(last) + i) % N);
            if (req[idx]) begin
                grant = idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pciecfg_arb.sv
// rtl/pciecfg_arb.sv - round-robin sequencer sharing one pciecfg core among N_REQ requesters
module pciecfg_arb
    import pciecfg_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 1024,
    parameter int SEL_W   = $clog2(N_REQ)
) (
    input logic           clk,
    input logic           rst,
    pciecfg_arb_if.master bus
);

    localparam int            TW         = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    PCIECFG_ARB_STATE_T state, state_d;
    logic [SEL_W-1:0]   grant, grant_d;
    logic [SEL_W-1:0]   last_grant, last_d;
    logic [SEL_W-1:0]   pick_grant;
    logic               pick_valid;
    logic [TW-1:0]      timer, timer_d;
    logic [3:0]         stale_cnt, stale_d;
    logic [15:0]        to_cnt, to_cnt_d;
    FIFO_PCIECFG_T      req_q, req_q_d;
    FIFO_PCIECFG_T      rsp_q, rsp_q_d;

    rr_pick #(.N(N_REQ), .W(SEL_W)) u_pick (
        .req   (~bus.req_empty),
        .last  (last_grant),
        .grant (pick_grant),
        .valid (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_IDLE;
            grant      <= '0;
            last_grant <= SEL_W'(N_REQ - 1);
            timer      <= '0;
            stale_cnt  <= '0;
            to_cnt     <= '0;
            req_q      <= '0;
            rsp_q      <= '0;
        end else begin
            state      <= state_d;
            grant      <= grant_d;
            last_grant <= last_d;
            timer      <= timer_d;
            stale_cnt  <= stale_d;
            to_cnt     <= to_cnt_d;
            req_q      <= req_q_d;
            rsp_q      <= rsp_q_d;
        end
    end

    always_comb begin
        state_d            = state;
        grant_d            = grant;
        last_d             = last_grant;
        timer_d            = timer;
        stale_d            = stale_cnt;
        to_cnt_d           = to_cnt;
        req_q_d            = req_q;
        rsp_q_d            = rsp_q;
        bus.req_rd_en      = '0;
        bus.rsp_wr_en      = '0;
        bus.rsp_din        = '0;
        bus.core_req_wr_en = 1'b0;
        bus.core_req_din   = '0;
        bus.core_rsp_rd_en = 1'b0;

        case (state)
            ARB_IDLE: begin
                // Late responses from earlier timeouts are drained while idle.
                if (stale_cnt != 4'd0 && !bus.core_rsp_empty) begin
                    bus.core_rsp_rd_en = 1'b1;
                    stale_d            = stale_cnt - 4'd1;
                end
                if (stale_cnt != PCIECFG_STALE_MAX && pick_valid) begin
                    grant_d = pick_grant;
                    state_d = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                bus.core_req_din = bus.req_dout[grant];
                if (!bus.core_req_full) begin
                    bus.core_req_wr_en   = 1'b1;
                    bus.req_rd_en[grant] = 1'b1;
                    req_q_d              = bus.req_dout[grant];
                    timer_d              = '0;
                    state_d              = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (!bus.core_rsp_empty) begin
                    bus.core_rsp_rd_en = 1'b1;
                    if (stale_cnt != 4'd0) begin
                        stale_d = stale_cnt - 4'd1;
                        if (timer != TIMER_LAST) timer_d = timer + 1'b1;
                    end else begin
                        rsp_q_d = bus.core_rsp_dout;
                        state_d = ARB_DELIVER;
                    end
                end else if (timer == TIMER_LAST) begin
                    rsp_q_d      = req_q;
                    rsp_q_d.data = PCIECFG_TIMEOUT_DATA;
                    if (stale_cnt != PCIECFG_STALE_MAX) stale_d = stale_cnt + 4'd1;
                    if (to_cnt != 16'hFFFF) to_cnt_d = to_cnt + 16'd1;
                    state_d = ARB_DELIVER;
                end else begin
                    timer_d = timer + 1'b1;
                end
            end
            ARB_DELIVER: begin
                bus.rsp_din = rsp_q;
                if (!bus.rsp_full[grant]) begin
                    bus.rsp_wr_en[grant] = 1'b1;
                    last_d               = grant;
                    state_d              = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign bus.busy             = (state != ARB_IDLE) || (stale_cnt != 4'd0);
    assign bus.stat_timeout_cnt = to_cnt;

endmodule

// File: tb/tb_pciecfg_arb.sv
// tb/tb_pciecfg_arb.sv - randomized self-checking bench for pciecfg_arb against FIFO and core models
module tb_pciecfg_arb;
    import pciecfg_pkg::*;

    localparam int N   = 2;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pciecfg_arb_if #(.N_REQ(N)) bus ();
    pciecfg_arb #(.N_REQ(N), .TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int core_lat = 5;
    int proto_err = 0;
    logic rst_cmd = 1'b1;
    logic [N-1:0] rsp_full_cmd = '0;
    logic core_full_cmd = 1'b0;
    bit core_silent = 1'b0;

    FIFO_PCIECFG_T req_fifo [N][$];
    FIFO_PCIECFG_T core_out [$];
    int            core_out_t [$];
    FIFO_PCIECFG_T held [$];
    FIFO_PCIECFG_T core_wr_log [$];
    int            core_wr_cyc [$];
    int            grant_log [$];
    FIFO_PCIECFG_T rsp_got [N][$];
    int            rsp_cyc [N][$];

    logic [N-1:0]  s_req_rd, s_rsp_wr;
    logic          s_core_wr, s_core_rd, s_busy;
    logic [15:0]   s_stat;
    FIFO_PCIECFG_T s_rsp_din, s_core_din;

    // Stand-in for the pciecfg core: echoes the request with a fixed data scramble.
    function automatic FIFO_PCIECFG_T core_fn(FIFO_PCIECFG_T w);
        FIFO_PCIECFG_T r;
        r      = w;
        r.wr   = 1'b0;
        r.data = w.data ^ 32'hA5A5_5A5A;
        return r;
    endfunction

    function automatic FIFO_PCIECFG_T rand_word();
        FIFO_PCIECFG_T w;
        w.tag  = 8'($urandom);
        w.wr   = 1'($urandom);
        w.be   = 4'($urandom);
        w.addr = 12'($urandom);
        w.data = $urandom;
        return w;
    endfunction

    // One clock: drive FIFO flags at negedge, sample strobes, apply them to the models.
    task automatic tick();
        @(negedge clk);
        rst = rst_cmd;
        for (int i = 0; i < N; i++) begin
            bus.req_empty[i] = (req_fifo[i].size() == 0);
            bus.req_dout[i]  = '0;
            if (req_fifo[i].size() != 0) bus.req_dout[i] = req_fifo[i][0];
        end
        bus.rsp_full       = rsp_full_cmd;
        bus.core_req_full  = core_full_cmd;
        bus.core_rsp_empty = 1'b1;
        bus.core_rsp_dout  = '0;
        if (core_out.size() != 0) begin
            bus.core_rsp_dout = core_out[0];
            if (core_out_t[0] <= cyc) bus.core_rsp_empty = 1'b0;
        end
        #1;
        s_req_rd   = bus.req_rd_en;
        s_rsp_wr   = bus.rsp_wr_en;
        s_core_wr  = bus.core_req_wr_en;
        s_core_rd  = bus.core_rsp_rd_en;
        s_busy     = bus.busy;
        s_stat     = bus.stat_timeout_cnt;
        s_rsp_din  = bus.rsp_din;
        s_core_din = bus.core_req_din;
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                if (s_req_rd[i]) begin
                    if (req_fifo[i].size() == 0) proto_err++;
                    else void'(req_fifo[i].pop_front());
                    grant_log.push_back(i);
                end
                if (s_rsp_wr[i]) begin
                    if (rsp_full_cmd[i]) proto_err++;
                    rsp_got[i].push_back(s_rsp_din);
                    rsp_cyc[i].push_back(cyc);
                end
            end
            if (s_core_rd) begin
                if (bus.core_rsp_empty) proto_err++;
                else begin
                    void'(core_out.pop_front());
                    void'(core_out_t.pop_front());
                end
            end
            if (s_core_wr) begin
                if (core_full_cmd) proto_err++;
                core_wr_log.push_back(s_core_din);
                core_wr_cyc.push_back(cyc);
                if (core_silent) held.push_back(core_fn(s_core_din));
                else begin
                    core_out.push_back(core_fn(s_core_din));
                    core_out_t.push_back(cyc + core_lat);
                end
            end
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst_cmd = 1'b1;
        tick();
        tick();
        for (int i = 0; i < N; i++) begin
            req_fifo[i].delete();
            rsp_got[i].delete();
            rsp_cyc[i].delete();
        end
        core_out.delete();
        core_out_t.delete();
        held.delete();
        core_wr_log.delete();
        core_wr_cyc.delete();
        grant_log.delete();
        core_silent   = 1'b0;
        rsp_full_cmd  = '0;
        core_full_cmd = 1'b0;
        rst_cmd       = 1'b0;
    endtask

    task automatic run_until(input int total, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (rsp_got[0].size() + rsp_got[1].size() >= total) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (rsp_got[0].size() + rsp_got[1].size() >= total) ok = 1'b1;
    endtask

    task automatic test_reset();
        int t0;
        rst_cmd = 1'b1;
        req_fifo[0].push_back(rand_word());
        req_fifo[1].push_back(rand_word());
        tick(); tick(); tick();
        n_total++; if ({s_req_rd, s_rsp_wr, s_core_wr, s_core_rd} !== '0) $display("FAIL reset_strobes: got %b expected 0", {s_req_rd, s_rsp_wr, s_core_wr, s_core_rd}); else n_pass++;
        n_total++; if (s_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", s_busy); else n_pass++;
        n_total++; if (s_stat !== 16'd0) $display("FAIL reset_stat: got %0d expected 0", s_stat); else n_pass++;
        n_total++; if ({s_rsp_din, s_core_din} !== '0) $display("FAIL reset_data: got %h expected 0", {s_rsp_din, s_core_din}); else n_pass++;
        rst_cmd = 1'b0;
        t0 = cyc;
        tick(); tick(); tick();
        n_total++; if ((grant_log.size() != 0 ? grant_log[0] : -1) !== 0) $display("FAIL reset_first_grant: got %0d expected 0", grant_log.size() != 0 ? grant_log[0] : -1); else n_pass++;
        n_total++; if ((core_wr_cyc.size() != 0 ? core_wr_cyc[0] : -1) !== t0 + 1) $display("FAIL reset_issue_cycle: got %0d expected %0d", core_wr_cyc.size() != 0 ? core_wr_cyc[0] : -1, t0 + 1); else n_pass++;
    endtask

    task automatic test_single();
        FIFO_PCIECFG_T w;
        int t0;
        bit ok;
        do_reset();
        core_lat = 5;
        w = rand_word();
        t0 = cyc;
        req_fifo[0].push_back(w);
        run_until(1, 40, ok);
        tick(); tick(); tick();
        n_total++; if (ok !== 1'b1) $display("FAIL single_done: got %b expected 1 (no response in budget)", ok); else n_pass++;
        n_total++; if ((core_wr_log.size() != 0 ? core_wr_log[0] : '0) !== w || core_wr_log.size() != 1) $display("FAIL single_core_word: got %h (count %0d) expected %h (count 1)", core_wr_log.size() != 0 ? core_wr_log[0] : '0, core_wr_log.size(), w); else n_pass++;
        n_total++; if ((core_wr_cyc.size() != 0 ? core_wr_cyc[0] : -1) !== t0 + 1) $display("FAIL single_issue_cycle: got %0d expected %0d", core_wr_cyc.size() != 0 ? core_wr_cyc[0] : -1, t0 + 1); else n_pass++;
        n_total++; if ((rsp_got[0].size() != 0 ? rsp_got[0][0] : '0) !== core_fn(w) || rsp_got[0].size() != 1) $display("FAIL single_rsp0: got %h (count %0d) expected %h (count 1)", rsp_got[0].size() != 0 ? rsp_got[0][0] : '0, rsp_got[0].size(), core_fn(w)); else n_pass++;
        n_total++; if ((rsp_cyc[0].size() != 0 ? rsp_cyc[0][0] : -1) !== t0 + 1 + core_lat + 1) $display("FAIL single_rsp_cycle: got %0d expected %0d", rsp_cyc[0].size() != 0 ? rsp_cyc[0][0] : -1, t0 + core_lat + 2); else n_pass++;
        n_total++; if (rsp_got[1].size() !== 0) $display("FAIL single_rsp1_quiet: got %0d writes expected 0", rsp_got[1].size()); else n_pass++;
        n_total++; if (s_busy !== 1'b0) $display("FAIL single_idle_after: got busy %b expected 0", s_busy); else n_pass++;
    endtask

    task automatic test_back_to_back();
        FIFO_PCIECFG_T w [N][4];
        int cnt [N];
        int last;
        int pick;
        bit ok;
        do_reset();
        core_lat = $urandom_range(1, 8);
        for (int i = 0; i < N; i++) begin
            cnt[i] = 4;
            for (int k = 0; k < 4; k++) begin
                w[i][k] = rand_word();
                req_fifo[i].push_back(w[i][k]);
            end
        end
        run_until(8, 400, ok);
        n_total++; if (ok !== 1'b1) $display("FAIL b2b_done: got %0d responses expected 8", rsp_got[0].size() + rsp_got[1].size()); else n_pass++;
        last = N - 1;
        for (int k = 0; k < 8; k++) begin
            pick = -1;
            for (int s = 1; s <= N; s++) begin
                if (pick < 0 && cnt[(last + s) % N] > 0) pick = (last + s) % N;
            end
            cnt[pick]--;
            last = pick;
            n_total++; if ((k < grant_log.size() ? grant_log[k] : -1) !== pick) $display("FAIL b2b_grant[%0d]: got %0d expected %0d", k, k < grant_log.size() ? grant_log[k] : -1, pick); else n_pass++;
        end
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 4; k++) begin
                n_total++; if ((k < rsp_got[i].size() ? rsp_got[i][k] : '0) !== core_fn(w[i][k])) $display("FAIL b2b_rsp[%0d][%0d]: got %h expected %h", i, k, k < rsp_got[i].size() ? rsp_got[i][k] : '0, core_fn(w[i][k])); else n_pass++;
            end
        end
        for (int k = 1; k < 8; k++) begin
            n_total++; if ((k < core_wr_cyc.size() ? core_wr_cyc[k] - core_wr_cyc[k-1] : -1) !== core_lat + 3) $display("FAIL b2b_spacing[%0d]: got %0d expected %0d", k, k < core_wr_cyc.size() ? core_wr_cyc[k] - core_wr_cyc[k-1] : -1, core_lat + 3); else n_pass++;
        end
    endtask

    task automatic test_core_full();
        FIFO_PCIECFG_T w;
        bit ok;
        do_reset();
        core_lat = $urandom_range(1, 6);
        core_full_cmd = 1'b1;
        w = rand_word();
        req_fifo[0].push_back(w);
        tick();
        for (int k = 0; k < 10; k++) tick();
        n_total++; if (core_wr_log.size() !== 0) $display("FAIL full_no_write: got %0d writes expected 0", core_wr_log.size()); else n_pass++;
        n_total++; if (grant_log.size() !== 0) $display("FAIL full_no_pop: got %0d pops expected 0", grant_log.size()); else n_pass++;
        core_full_cmd = 1'b0;
        run_until(1, 40, ok);
        tick(); tick();
        n_total++; if (core_wr_log.size() !== 1 || grant_log.size() !== 1) $display("FAIL full_single_issue: got %0d writes %0d pops expected 1 and 1", core_wr_log.size(), grant_log.size()); else n_pass++;
        n_total++; if ((rsp_got[0].size() != 0 ? rsp_got[0][0] : '0) !== core_fn(w)) $display("FAIL full_rsp: got %h expected %h", rsp_got[0].size() != 0 ? rsp_got[0][0] : '0, core_fn(w)); else n_pass++;
    endtask

    task automatic test_timeout();
        FIFO_PCIECFG_T w0, w1, exp;
        bit ok;
        do_reset();
        core_lat = $urandom_range(2, 6);
        core_silent = 1'b1;
        w0 = rand_word();
        req_fifo[0].push_back(w0);
        run_until(1, 60, ok);
        exp = w0;
        exp.data = 32'hFFFF_FFFF;
        n_total++; if (ok !== 1'b1) $display("FAIL tmo_done: got no response expected timeout response"); else n_pass++;
        n_total++; if ((rsp_got[0].size() != 0 ? rsp_got[0][0] : '0) !== exp) $display("FAIL tmo_word: got %h expected %h", rsp_got[0].size() != 0 ? rsp_got[0][0] : '0, exp); else n_pass++;
        n_total++; if ((rsp_cyc[0].size() != 0 && core_wr_cyc.size() != 0 ? rsp_cyc[0][0] - core_wr_cyc[0] : -1) !== TMO + 1) $display("FAIL tmo_latency: got %0d expected %0d", rsp_cyc[0].size() != 0 && core_wr_cyc.size() != 0 ? rsp_cyc[0][0] - core_wr_cyc[0] : -1, TMO + 1); else n_pass++;
        tick(); tick();
        n_total++; if (s_stat !== 16'd1) $display("FAIL tmo_stat: got %0d expected 1", s_stat); else n_pass++;
        n_total++; if (s_busy !== 1'b1) $display("FAIL tmo_stale_busy: got %b expected 1", s_busy); else n_pass++;
        core_silent = 1'b0;
        w1 = rand_word();
        req_fifo[0].push_back(w1);
        if ($urandom_range(0, 1) == 1) tick();
        if (held.size() != 0) begin
            core_out.push_back(held[0]);
            core_out_t.push_back(cyc);
            held.delete();
        end
        run_until(2, 40, ok);
        tick(); tick();
        n_total++; if ((rsp_got[0].size() > 1 ? rsp_got[0][1] : '0) !== core_fn(w1) || rsp_got[0].size() != 2) $display("FAIL tmo_next_rsp: got %h (count %0d) expected %h (count 2)", rsp_got[0].size() > 1 ? rsp_got[0][1] : '0, rsp_got[0].size(), core_fn(w1)); else n_pass++;
        n_total++; if (core_out.size() !== 0 || rsp_got[1].size() !== 0) $display("FAIL tmo_late_dropped: got %0d left in core, %0d to req1 expected 0 and 0", core_out.size(), rsp_got[1].size()); else n_pass++;
        n_total++; if (s_busy !== 1'b0 || s_stat !== 16'd1) $display("FAIL tmo_settled: got busy %b stat %0d expected 0 and 1", s_busy, s_stat); else n_pass++;
    endtask

    task automatic test_rsp_full();
        FIFO_PCIECFG_T w0, w1;
        bit ok;
        do_reset();
        core_lat = 3;
        rsp_full_cmd = 2'b01;
        w0 = rand_word();
        w1 = rand_word();
        req_fifo[0].push_back(w0);
        tick();
        req_fifo[1].push_back(w1);
        for (int k = 0; k < 25; k++) tick();
        n_total++; if (grant_log.size() !== 1 || rsp_got[0].size() !== 0) $display("FAIL hold_no_grant: got %0d grants %0d deliveries expected 1 and 0", grant_log.size(), rsp_got[0].size()); else n_pass++;
        n_total++; if (s_busy !== 1'b1) $display("FAIL hold_busy: got %b expected 1", s_busy); else n_pass++;
        rsp_full_cmd = '0;
        run_until(2, 40, ok);
        n_total++; if (ok !== 1'b1 || (grant_log.size() > 1 ? grant_log[1] : -1) !== 1) $display("FAIL hold_then_req1: got done %b grant %0d expected 1 and 1", ok, grant_log.size() > 1 ? grant_log[1] : -1); else n_pass++;
        n_total++; if ((rsp_got[0].size() != 0 ? rsp_got[0][0] : '0) !== core_fn(w0) || (rsp_got[1].size() != 0 ? rsp_got[1][0] : '0) !== core_fn(w1)) $display("FAIL hold_routing: got %h %h expected %h %h", rsp_got[0].size() != 0 ? rsp_got[0][0] : '0, rsp_got[1].size() != 0 ? rsp_got[1][0] : '0, core_fn(w0), core_fn(w1)); else n_pass++;
        n_total++; if (!(rsp_cyc[0].size() != 0 && rsp_cyc[1].size() != 0 && rsp_cyc[1][0] > rsp_cyc[0][0])) $display("FAIL hold_order: got req1 delivery not after req0 expected req0 first"); else n_pass++;
    endtask

    task automatic test_reset_mid();
        FIFO_PCIECFG_T a, b, c, d;
        int base;
        bit ok;
        do_reset();
        core_lat = 8;
        a = rand_word();
        req_fifo[0].push_back(a);
        run_until(1, 40, ok);
        tick();
        b = rand_word();
        req_fifo[1].push_back(b);
        tick(); tick(); tick();
        n_total++; if (core_wr_log.size() !== 2 || s_busy !== 1'b1) $display("FAIL mid_in_wait: got %0d writes busy %b expected 2 and 1", core_wr_log.size(), s_busy); else n_pass++;
        rst_cmd = 1'b1;
        tick();
        core_out.delete();
        core_out_t.delete();
        rst_cmd = 1'b0;
        c = rand_word();
        d = rand_word();
        req_fifo[0].push_back(c);
        req_fifo[1].push_back(d);
        base = grant_log.size();
        tick();
        n_total++; if ({s_req_rd, s_rsp_wr, s_core_wr, s_core_rd, s_busy} !== '0) $display("FAIL mid_outputs_zero: got %b expected 0", {s_req_rd, s_rsp_wr, s_core_wr, s_core_rd, s_busy}); else n_pass++;
        n_total++; if ({s_rsp_din, s_core_din} !== '0) $display("FAIL mid_data_zero: got %h expected 0", {s_rsp_din, s_core_din}); else n_pass++;
        run_until(3, 80, ok);
        n_total++; if ((grant_log.size() > base ? grant_log[base] : -1) !== 0 || (grant_log.size() > base + 1 ? grant_log[base+1] : -1) !== 1) $display("FAIL mid_order: got %0d,%0d expected 0,1", grant_log.size() > base ? grant_log[base] : -1, grant_log.size() > base + 1 ? grant_log[base+1] : -1); else n_pass++;
        n_total++; if ((rsp_got[0].size() > 1 ? rsp_got[0][1] : '0) !== core_fn(c) || (rsp_got[1].size() != 0 ? rsp_got[1][0] : '0) !== core_fn(d) || rsp_got[1].size() != 1) $display("FAIL mid_rsp: got %h %h expected %h %h", rsp_got[0].size() > 1 ? rsp_got[0][1] : '0, rsp_got[1].size() != 0 ? rsp_got[1][0] : '0, core_fn(c), core_fn(d)); else n_pass++;
    endtask

    task automatic test_protocol();
        n_total++; if (proto_err !== 0) $display("FAIL protocol: got %0d strobes on empty/full FIFOs expected 0", proto_err); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_core_full();
        test_timeout();
        test_rsp_full();
        test_reset_mid();
        test_protocol();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
